// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-requester SDRAM arbiter.
// Optional feature macro: ARB_FIXED_PRIO_EN (tie always goes to M0).
// No logic here beyond the tie-break helper used by the top.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_t;

  typedef logic id_t;

  localparam id_t ID_M0 = 1'b0;
  localparam id_t ID_M1 = 1'b1;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int PEND_DEPTH_DEF = 8;

  // Choose the next owner from the live requests; last is the most recently served requester.
  function automatic gnt_t arb_pick(input logic r0, input logic r1, input id_t last);
    gnt_t g;
    g = GNT_NONE;
    if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
      g = GNT_M0;
`else
      g = (last == ID_M0) ? GNT_M1 : GNT_M0;
`endif
    end else if (r0) begin
      g = GNT_M0;
    end else if (r1) begin
      g = GNT_M1;
    end
    return g;
  endfunction

endpackage

// File: rtl/sdram_arbiter_pend_fifo.sv
// Pending-read ID FIFO: remembers which requester issued each outstanding read.
// Latency: push visible on head/count the next cycle; head is a combinational read of storage.
// Backpressure: full stays asserted for a cycle even if a pop happens; push when full / pop when empty ignored.
module pend_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = PEND_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  id_t  push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output id_t  head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  id_t           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one SDRAM controller; routes read data back by issue order.
// Latency: grant registered (1 cycle from idle), downstream mux and readdatavalid routing combinational.
// Backpressure: sdram_waitrequest or a full pending FIFO (reads only) stalls the owner; others always wait. Macro ARB_FIXED_PRIO_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PEND_DEPTH = PEND_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] sdram_address,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [DATA_W-1:0] sdram_writedata,
  input  logic              sdram_waitrequest,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_readdatavalid,
  output logic              err
);

  gnt_t gnt;
  gnt_t gnt_nxt;
  id_t  last;
  id_t  eff_last;
  id_t  gnt_id;
  id_t  head;
  logic req0;
  logic req1;
  logic gnt_req;
  logic accept;
  logic reeval;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic rw_conflict;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign gnt_id = (gnt == GNT_M1) ? ID_M1 : ID_M0;

  // Downstream mux and per-port waitrequest; reads are held off while the pending FIFO is full.
  always_comb begin
    sdram_address   = '0;
    sdram_writedata = '0;
    sdram_read      = 1'b0;
    sdram_write     = 1'b0;
    m0_waitrequest  = 1'b1;
    m1_waitrequest  = 1'b1;
    gnt_req         = 1'b0;
    rw_conflict     = 1'b0;
    case (gnt)
      GNT_M0: begin
        sdram_address   = m0_address;
        sdram_writedata = m0_writedata;
        sdram_read      = m0_read & ~full;
        sdram_write     = m0_write;
        m0_waitrequest  = sdram_waitrequest | (m0_read & full);
        gnt_req         = req0;
        rw_conflict     = m0_read & m0_write;
      end
      GNT_M1: begin
        sdram_address   = m1_address;
        sdram_writedata = m1_writedata;
        sdram_read      = m1_read & ~full;
        sdram_write     = m1_write;
        m1_waitrequest  = sdram_waitrequest | (m1_read & full);
        gnt_req         = req1;
        rw_conflict     = m1_read & m1_write;
      end
      default: begin
      end
    endcase
  end

  assign accept = (sdram_read | sdram_write) & ~sdram_waitrequest;

  // Re-arbitrate on a completed transfer or when the owner has dropped its request; a stalled
  // owner is still requesting, so its grant is never revoked. Re-arbitrating an idle owner
  // keeps a requester that finished from locking the other one out.
  assign reeval   = accept | ~gnt_req;
  assign eff_last = accept ? gnt_id : last;
  assign gnt_nxt  = reeval ? arb_pick(req0, req1, eff_last) : gnt;

  assign push = accept & sdram_read;
  assign pop  = sdram_readdatavalid & ~empty;

  pend_fifo #(
    .DEPTH(PEND_DEPTH)
  ) u_pend_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (gnt_id),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;
  assign m0_readdatavalid = sdram_readdatavalid & ~empty & (head == ID_M0);
  assign m1_readdatavalid = sdram_readdatavalid & ~empty & (head == ID_M1);

  // Grant, last-served and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt  <= GNT_NONE;
      last <= ID_M1;
      err  <= 1'b0;
    end else begin
      gnt <= gnt_nxt;
      if (accept) begin
        last <= gnt_id;
      end
      if ((sdram_readdatavalid & empty) | rw_conflict) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a queue-based model.
module tb_sdram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    m_rd;
  logic [1:0]    m_wr;
  logic [AW-1:0] ma [2];
  logic [DW-1:0] mwd [2];
  logic          s_wait;
  logic          s_rdv;
  logic [DW-1:0] s_rdata;

  logic          o_wait0, o_wait1, o_rdv0, o_rdv1, o_sread, o_swrite, o_err;
  logic [DW-1:0] o_rdata0, o_rdata1, o_swd;
  logic [AW-1:0] o_saddr;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PEND_DEPTH(PD)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .m0_address          (ma[0]),
    .m0_read             (m_rd[0]),
    .m0_write            (m_wr[0]),
    .m0_writedata        (mwd[0]),
    .m0_waitrequest      (o_wait0),
    .m0_readdata         (o_rdata0),
    .m0_readdatavalid    (o_rdv0),
    .m1_address          (ma[1]),
    .m1_read             (m_rd[1]),
    .m1_write            (m_wr[1]),
    .m1_writedata        (mwd[1]),
    .m1_waitrequest      (o_wait1),
    .m1_readdata         (o_rdata1),
    .m1_readdatavalid    (o_rdv1),
    .sdram_address       (o_saddr),
    .sdram_read          (o_sread),
    .sdram_write         (o_swrite),
    .sdram_writedata     (o_swd),
    .sdram_waitrequest   (s_wait),
    .sdram_readdata      (s_rdata),
    .sdram_readdatavalid (s_rdv),
    .err                 (o_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model state: owner (0 none, 1 = m0, 2 = m1), last served port, pending-ID queue, error flag.
  int  mg   = 0;
  int  ml   = 1;
  bit  pq[$];
  bit  merr = 1'b0;
  bit  acc [2];
  bit  pushed;

  logic          e_sread, e_swrite, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          e_wait [2];
  logic          e_rdv [2];

  logic          smp_sread, smp_swrite, smp_wait0, smp_wait1, smp_rdv0, smp_rdv1, smp_err;
  logic [AW-1:0] smp_addr;
  logic [DW-1:0] smp_rdata0, smp_rdata1;

  int rq[$];
  int last_due = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endfunction

  function automatic void model_comb();
    bit full, empty;
    full  = (pq.size() == PD);
    empty = (pq.size() == 0);
    e_sread = 1'b0; e_swrite = 1'b0; e_addr = '0; e_wd = '0;
    e_err = merr;
    for (int x = 0; x < 2; x++) begin
      e_wait[x] = 1'b1;
      e_rdv[x]  = s_rdv && !empty && (pq[0] == x[0]);
    end
    if (mg != 0) begin
      int p;
      p = mg - 1;
      e_addr    = ma[p];
      e_wd      = mwd[p];
      e_sread   = m_rd[p] && !full;
      e_swrite  = m_wr[p];
      e_wait[p] = s_wait || (m_rd[p] && full);
    end
  endfunction

  function automatic void model_update();
    bit accept, r0, r1, greq;
    int eff;
    if (!rst_n) begin
      mg = 0; ml = 1; pq.delete(); merr = 1'b0;
      acc[0] = 1'b0; acc[1] = 1'b0; pushed = 1'b0;
      return;
    end
    r0 = m_rd[0] | m_wr[0];
    r1 = m_rd[1] | m_wr[1];
    accept = (e_sread || e_swrite) && !s_wait;
    acc[0] = r0 && !e_wait[0];
    acc[1] = r1 && !e_wait[1];
    pushed = accept && e_sread;
    if (mg != 0 && m_rd[mg-1] && m_wr[mg-1]) merr = 1'b1;
    if (s_rdv) begin
      if (pq.size() == 0) merr = 1'b1;
      else void'(pq.pop_front());
    end
    if (pushed) pq.push_back(mg == 2);
    greq = (mg == 1) ? r0 : (mg == 2) ? r1 : 1'b0;
    if (accept || !greq) begin
      eff = accept ? (mg - 1) : ml;
      if (accept) ml = mg - 1;
      if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
        mg = 1;
`else
        mg = (eff == 0) ? 2 : 1;
`endif
      end else if (r0) mg = 1;
      else if (r1) mg = 2;
      else mg = 0;
    end
  endfunction

  // One clock: compare every output mid-cycle, then advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    smp_sread = o_sread; smp_swrite = o_swrite; smp_addr = o_saddr;
    smp_wait0 = o_wait0; smp_wait1 = o_wait1; smp_rdv0 = o_rdv0; smp_rdv1 = o_rdv1;
    smp_rdata0 = o_rdata0; smp_rdata1 = o_rdata1; smp_err = o_err;
    check("sdram_read", o_sread, e_sread);
    check("sdram_write", o_swrite, e_swrite);
    check("sdram_address", o_saddr, e_addr);
    check("sdram_writedata", o_swd, e_wd);
    check("m0_waitrequest", o_wait0, e_wait[0]);
    check("m1_waitrequest", o_wait1, e_wait[1]);
    check("m0_readdatavalid", o_rdv0, e_rdv[0]);
    check("m1_readdatavalid", o_rdv1, e_rdv[1]);
    check("m0_readdata", o_rdata0, s_rdata);
    check("m1_readdata", o_rdata1, s_rdata);
    check("err", o_err, e_err);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    m_rd = 2'b00; m_wr = 2'b00;
    ma[0] = '0; ma[1] = '0; mwd[0] = '0; mwd[1] = '0;
    s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_rd  = 2'b11;
    ma[0] = 32'h10; ma[1] = 32'h20;
    @(posedge clk);
    #1;

    // Reset held with both reads asserted.
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rst_sread", smp_sread, 1'b0);
      check("rst_wait0", smp_wait0, 1'b1);
      check("rst_wait1", smp_wait1, 1'b1);
      check("rst_err", smp_err, 1'b0);
    end
    rst_n = 1'b1;
    idle_inputs();
    do_reset();

    // Tie: both read continuously; order m0, m1, m0, m1 (fixed priority: m0 each time).
    m_rd = 2'b11; ma[0] = 32'h10; ma[1] = 32'h20;
    cycle();
    check("tie_c0_sread", smp_sread, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      logic [AW-1:0] ex;
`ifdef ARB_FIXED_PRIO_EN
      ex = 32'h10;
`else
      ex = (k % 2 == 1) ? 32'h10 : 32'h20;
`endif
      cycle();
      check("tie_addr", smp_addr, ex);
    end
    m_rd = 2'b00;
    cycle();
    s_rdv = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    do_reset();

    // Routing: m0 reads 0x100, m1 reads 0x200, returns 0xAAAA / 0xBBBB.
    for (int c = 0; c <= 10; c++) begin
      m_rd[0] = (c <= 1);
      m_rd[1] = (c == 2 || c == 3);
      ma[0] = 32'h100; ma[1] = 32'h200;
      s_rdv = (c == 6 || c == 9);
      s_rdata = (c == 6) ? 32'hAAAA : (c == 9) ? 32'hBBBB : 32'h0;
      cycle();
      if (c == 1) check("route_addr0", smp_addr, 32'h100);
      if (c == 3) check("route_addr1", smp_addr, 32'h200);
      if (c == 6) begin
        check("route_rdv0", smp_rdv0, 1'b1);
        check("route_data0", smp_rdata0, 32'hAAAA);
        check("route_rdv1_off", smp_rdv1, 1'b0);
      end
      if (c == 7) check("route_rdv0_pulse", smp_rdv0, 1'b0);
      if (c == 9) begin
        check("route_rdv1", smp_rdv1, 1'b1);
        check("route_data1", smp_rdata1, 32'hBBBB);
        check("route_rdv0_off", smp_rdv0, 1'b0);
      end
      if (c == 10) check("route_rdv1_pulse", smp_rdv1, 1'b0);
    end
    do_reset();

    // Full: 8 reads outstanding, 9th held until one return has been popped.
    for (int c = 0; c <= 19; c++) begin
      m_rd[0] = (c <= 11);
      ma[0] = 32'h500;
      s_rdv = (c == 10) || (c >= 12);
      s_rdata = 32'(c);
      cycle();
      if (c == 9) begin
        check("full_sread", smp_sread, 1'b0);
        check("full_wait0", smp_wait0, 1'b1);
      end
      if (c == 10) check("full_pop_same_cycle", smp_sread, 1'b0);
      if (c == 11) begin
        check("full_resume_sread", smp_sread, 1'b1);
        check("full_resume_wait0", smp_wait0, 1'b0);
      end
    end
    do_reset();

    // Stall hold: m1 write stalled 4 cycles while m0 waits to read.
    for (int c = 0; c <= 8; c++) begin
      m_wr[1] = (c <= 5);
      m_rd[0] = (c >= 1 && c <= 6);
      ma[0] = 32'h400; ma[1] = 32'h300; mwd[1] = 32'h5555;
      s_wait = (c <= 4);
      s_rdv = (c == 7);
      cycle();
      if (c >= 1 && c <= 4) begin
        check("stall_swrite", smp_swrite, 1'b1);
        check("stall_addr", smp_addr, 32'h300);
        check("stall_wait0", smp_wait0, 1'b1);
      end
      if (c == 5) check("stall_accept_wait1", smp_wait1, 1'b0);
      if (c == 6) begin
        check("stall_m0_sread", smp_sread, 1'b1);
        check("stall_m0_addr", smp_addr, 32'h400);
      end
      if (c == 7) check("stall_m0_rdv", smp_rdv0, 1'b1);
    end
    do_reset();

    // Error: stray readdatavalid with nothing pending.
    s_rdv = 1'b1; s_rdata = 32'h1234;
    cycle();
    check("err_no_rdv0", smp_rdv0, 1'b0);
    check("err_no_rdv1", smp_rdv1, 1'b0);
    check("err_not_yet", smp_err, 1'b0);
    s_rdv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("err_sticky", smp_err, 1'b1);
    end
    do_reset();
    cycle();
    check("err_cleared", smp_err, 1'b0);

    // Randomized traffic with random stalls and in-order read returns.
    acc[0] = 1'b0; acc[1] = 1'b0;
    last_due = cyc;
    for (int i = 0; i < 3000; i++) begin
      for (int x = 0; x < 2; x++) begin
        if (!((m_rd[x] || m_wr[x]) && !acc[x])) begin
          int r;
          r = $urandom_range(0, 3);
          m_rd[x] = (r == 1 || r == 3);
          m_wr[x] = (r == 2);
          ma[x]   = $urandom;
          mwd[x]  = $urandom;
        end
      end
      s_wait  = ($urandom_range(0, 3) == 0);
      s_rdv   = (rq.size() > 0) && (rq[0] <= cyc);
      s_rdata = $urandom;
      cycle();
      if (s_rdv) void'(rq.pop_front());
      if (pushed) begin
        int due;
        due = cyc + $urandom_range(0, 11);
        if (due <= last_due) due = last_due + 1;
        rq.push_back(due);
        last_due = due;
      end
    end
    m_rd = 2'b00; m_wr = 2'b00; s_wait = 1'b0;
    for (int i = 0; i < 200 && rq.size() > 0; i++) begin
      s_rdv   = (rq[0] <= cyc);
      s_rdata = $urandom;
      cycle();
      if (s_rdv) void'(rq.pop_front());
    end
    s_rdv = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
